lcd_sequencer: RTL and testbench

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_delay_counter.sv | 24 ++
 rtl/lcd_sequencer.sv | 152 +++++++++++++++
 tb/tb_lcd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write sequencer.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_LOAD,
      IDLE,
      SETUP,
      EN_HIGH,
      HOLD,
      WAIT
   } lcd_state_t;

   localparam int INIT_LEN = 6;
   localparam logic [7:0] INIT_TABLE [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   // Clear and home commands need the long post-transfer wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable countdown that parks at zero; shared by every timed sequencer state.
module lcd_delay_counter
   import lcd_pkg::*;
#(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// Write-only LCD byte sequencer with setup/enable/hold/wait timing.
// Define LCD_AUTO_INIT_EN to add the power-on wait and built-in init sequence.
module lcd_sequencer
   import lcd_pkg::*;
#(
   parameter int POWERON_WAIT_CYC = 750000,
   parameter int SETUP_CYC        = 3,
   parameter int EN_PULSE_CYC     = 25,
   parameter int CMD_WAIT_CYC     = 2500,
   parameter int CLEAR_WAIT_CYC   = 82000
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int CNT_W = 20;

   function automatic logic [CNT_W-1:0] cyc_to_load(input int n);
      return (n > 1) ? CNT_W'(n - 1) : '0;
   endfunction

   lcd_state_t       state;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;
   logic             accept;
`ifdef LCD_AUTO_INIT_EN
   logic [2:0]       init_idx;
`endif

   assign req_ready = (state == IDLE) && init_done;
   assign accept    = req_valid && req_ready;
   assign busy      = (state != IDLE);
   assign lcd_rw    = 1'b0;

   // The counter is loaded on the same edge that enters the next timed state.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = cyc_to_load(SETUP_CYC);
      if (reset_reset) begin
         cnt_load = 1'b1;
         cnt_val  = cyc_to_load(POWERON_WAIT_CYC);
      end else begin
         case (state)
            IDLE:      cnt_load = accept;
            INIT_LOAD: cnt_load = 1'b1;
            SETUP: begin
               cnt_load = cnt_zero;
               cnt_val  = cyc_to_load(EN_PULSE_CYC);
            end
            EN_HIGH:   cnt_load = cnt_zero;
            HOLD: begin
               cnt_load = cnt_zero;
               cnt_val  = is_long_cmd(lcd_rs, lcd_data) ? cyc_to_load(CLEAR_WAIT_CYC)
                                                        : cyc_to_load(CMD_WAIT_CYC);
            end
            default: ;
         endcase
      end
   end

   lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
      .clk      (clk_clk),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state     <= PWR_WAIT;
         init_done <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
`ifdef LCD_AUTO_INIT_EN
         init_idx  <= '0;
`endif
      end else begin
         case (state)
            PWR_WAIT: begin
`ifdef LCD_AUTO_INIT_EN
               if (cnt_zero)
                  state <= INIT_LOAD;
`else
               state     <= IDLE;
               init_done <= 1'b1;
`endif
            end
            INIT_LOAD: begin
`ifdef LCD_AUTO_INIT_EN
               lcd_rs   <= 1'b0;
               lcd_data <= INIT_TABLE[init_idx];
               init_idx <= init_idx + 1'b1;
               state    <= SETUP;
`else
               state    <= IDLE;
`endif
            end
            IDLE: begin
               if (accept) begin
                  lcd_rs   <= req_rs;
                  lcd_data <= req_data;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_zero) begin
                  lcd_en <= 1'b1;
                  state  <= EN_HIGH;
               end
            end
            EN_HIGH: begin
               if (cnt_zero) begin
                  lcd_en <= 1'b0;
                  state  <= HOLD;
               end
            end
            HOLD: begin
               if (cnt_zero)
                  state <= WAIT;
            end
            WAIT: begin
               if (cnt_zero) begin
`ifdef LCD_AUTO_INIT_EN
                  if (!init_done && init_idx < 3'(INIT_LEN)) begin
                     state <= INIT_LOAD;
                  end else begin
                     init_done <= 1'b1;
                     state     <= IDLE;
                  end
`else
                  state <= IDLE;
`endif
               end
            end
            default: state <= PWR_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed + randomized bench for lcd_sequencer with a transaction-level timing model.
module tb_lcd_sequencer;

   localparam int P_PWR   = 100;
   localparam int P_SETUP = 2;
   localparam int P_EN    = 4;
   localparam int P_CMD   = 10;
   localparam int P_CLR   = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_rs = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   lcd_sequencer #(
      .POWERON_WAIT_CYC (P_PWR),
      .SETUP_CYC        (P_SETUP),
      .EN_PULSE_CYC     (P_EN),
      .CMD_WAIT_CYC     (P_CMD),
      .CLEAR_WAIT_CYC   (P_CLR)
   ) dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .req_valid   (req_valid),
      .req_rs      (req_rs),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .init_done   (init_done),
      .busy        (busy),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_en      (lcd_en),
      .lcd_data    (lcd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         rise;
      int         width;
   } pulse_t;

   pulse_t pulses[$];
   pulse_t cur;
   logic   prev_en = 1'b0;
   int     unstable = 0;
   int     rw_high = 0;

   // Enable-pulse monitor: one record per completed lcd_en pulse.
   always @(negedge clk) begin
      if (lcd_rw !== 1'b0) rw_high++;
      if (lcd_en === 1'b1 && prev_en !== 1'b1) begin
         cur.rs    = lcd_rs;
         cur.data  = lcd_data;
         cur.rise  = cyc;
         cur.width = 1;
      end else if (lcd_en === 1'b1) begin
         cur.width++;
         if (lcd_data !== cur.data || lcd_rs !== cur.rs) unstable++;
      end else if (prev_en === 1'b1) begin
         pulses.push_back(cur);
      end
      prev_en = lcd_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_wait(input logic rs, input logic [7:0] d);
      return (!rs && d >= 8'd1 && d <= 8'd3) ? P_CLR : P_CMD;
   endfunction

   function automatic int exp_latency(input logic rs, input logic [7:0] d);
      return P_SETUP + P_EN + P_SETUP + exp_wait(rs, d);
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic send(input logic rs, input logic [7:0] d, input string tag);
      bit     ok;
      int     a, lat;
      pulse_t p;
      wait_ready(ok);
      chk({tag, "_ready"}, ok, 1);
      req_valid = 1'b1;
      req_rs    = rs;
      req_data  = d;
      @(negedge clk);
      a = cyc;
      req_valid = 1'b0;
      chk({tag, "_ready_low"}, req_ready, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_lcd_data"}, lcd_data, d);
      chk({tag, "_lcd_rs"}, lcd_rs, rs);
      lat = 0;
      while (req_ready !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_latency(rs, d));
      chk({tag, "_npulse"}, pulses.size(), 1);
      if (pulses.size() > 0) begin
         p = pulses.pop_front();
         chk({tag, "_pulse_data"}, p.data, d);
         chk({tag, "_pulse_rs"}, p.rs, rs);
         chk({tag, "_pulse_start"}, p.rise - a, P_SETUP);
         chk({tag, "_pulse_width"}, p.width, P_EN);
      end
      pulses.delete();
   endtask

`ifdef LCD_AUTO_INIT_EN
   task automatic check_init(input int r, input string tag);
      bit         ok;
      logic [7:0] tbl [6];
      tbl = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (init_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_init_done"}, ok, 1);
      chk({tag, "_init_npulse"}, pulses.size(), 6);
      if (pulses.size() > 0)
         chk({tag, "_no_early_pulse"}, (pulses[0].rise - r) > P_PWR, 1);
      for (int i = 0; i < pulses.size() && i < 6; i++) begin
         chk({tag, "_init_data"}, pulses[i].data, tbl[i]);
         chk({tag, "_init_rs"}, pulses[i].rs, 0);
         chk({tag, "_init_width"}, pulses[i].width, P_EN);
      end
      chk({tag, "_ready_after_init"}, req_ready, 1);
      pulses.delete();
   endtask
`endif

   initial begin
      int         r;
      int         a [3];
      bit         ok;
      logic [7:0] b [3];
      logic       rrs;
      logic [7:0] rd;
      pulse_t     p;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_lcd_en", lcd_en, 0);
      chk("rst_lcd_rs", lcd_rs, 0);
      chk("rst_lcd_rw", lcd_rw, 0);
      chk("rst_lcd_data", lcd_data, 8'h00);
      chk("rst_init_done", init_done, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 1);
      rst = 1'b0;
      r = cyc;

`ifdef LCD_AUTO_INIT_EN
      check_init(r, "boot");
`else
      @(negedge clk);
      chk("boot_init_done", init_done, 1);
      chk("boot_ready", req_ready, 1);
      chk("boot_busy", busy, 0);
      chk("boot_no_pulse", pulses.size(), 0);
`endif

      // Directed transfers, including the clear/home boundary
      send(1'b1, 8'h41, "char_41");
      send(1'b0, 8'h01, "cmd_clear");
      send(1'b1, 8'h01, "data_01");
      send(1'b0, 8'h02, "cmd_home");
      send(1'b0, 8'h03, "cmd_home_alt");
      send(1'b0, 8'h04, "cmd_04");
      send(1'b0, 8'h00, "cmd_00");

      // Randomized transfers, biased toward the long-wait commands
      repeat (12) begin
         rrs = 1'($urandom_range(0, 1));
         rd  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         send(rrs, rd, "rand");
      end

      // req_valid held across three back-to-back bytes
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom_range(0, 84) + i * 85);
      req_valid = 1'b1;
      req_rs    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_data = b[i];
         wait_ready(ok);
         chk("b2b_ready", ok, 1);
         @(negedge clk);
         a[i] = cyc;
      end
      req_valid = 1'b0;
      wait_ready(ok);
      chk("b2b_final_ready", ok, 1);
      chk("b2b_npulse", pulses.size(), 3);
      for (int i = 0; i < 3 && pulses.size() > 0; i++) begin
         p = pulses.pop_front();
         chk("b2b_data", p.data, b[i]);
         chk("b2b_start", p.rise - a[i], P_SETUP);
      end
      chk("b2b_gap01", a[1] - a[0], exp_latency(1'b1, b[0]) + 1);
      chk("b2b_gap12", a[2] - a[1], exp_latency(1'b1, b[1]) + 1);
      pulses.delete();

      // Reset in the middle of the enable pulse
      wait_ready(ok);
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (lcd_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("midrst_en_seen", ok, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_lcd_en", lcd_en, 0);
      chk("midrst_init_done", init_done, 0);
      chk("midrst_busy", busy, 1);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_lcd_data", lcd_data, 8'h00);
      @(negedge clk);
      pulses.delete();
      rst = 1'b0;
      r = cyc;
`ifdef LCD_AUTO_INIT_EN
      check_init(r, "reinit");
`else
      @(negedge clk);
      chk("reinit_init_done", init_done, 1);
      chk("reinit_no_pulse", pulses.size(), 0);
`endif
      send(1'b1, 8'h42, "after_reset");

      chk("lcd_rw_never_high", rw_high, 0);
      chk("pulse_data_stable", unstable, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
